// File: rtl/mips_multicycle_control.sv
// mips_multicycle_control
// Multicycle MIPS main control unit (lw, sw, R-type, beq, addi, j).
// Moore FSM: every datapath control is decoded from the current state,
// with mem_ready and zero qualifying only the enables that depend on them.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   opcode     instruction register bits [31:26]
//   zero       ALU zero flag
//   mem_ready  memory access completes this cycle
//   pcen, iord, memread, memwrite, irwrite, regdst, memtoreg, regwrite,
//   alusrca, alusrcb[1:0], aluop[1:0], pcsrc[1:0]
//              datapath controls
//   illegal_op one-cycle pulse after an unsupported opcode is decoded
//   busy       high in every state except FETCH

module mips_multicycle_control (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pcen,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       irwrite,
  output logic       regdst,
  output logic       memtoreg,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsrc,
  output logic       illegal_op,
  output logic       busy
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    REXEC  = 4'd6,
    RWB    = 4'd7,
    BEQEX  = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JEX    = 4'd11
  } state_t;

  state_t state;
  state_t next_state;
  logic   illegal_q;
  logic   illegal_next;

  // The illegal-opcode flag is registered so that illegal_op depends only on
  // stored state; it pulses in the FETCH cycle that follows the bad DECODE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= FETCH;
      illegal_q <= 1'b0;
    end else begin
      state     <= next_state;
      illegal_q <= illegal_next;
    end
  end

  always_comb begin
    next_state   = FETCH;
    illegal_next = 1'b0;
    pcen         = 1'b0;
    iord         = 1'b0;
    memread      = 1'b0;
    memwrite     = 1'b0;
    irwrite      = 1'b0;
    regdst       = 1'b0;
    memtoreg     = 1'b0;
    regwrite     = 1'b0;
    alusrca      = 1'b0;
    alusrcb      = 2'b00;
    aluop        = 2'b00;
    pcsrc        = 2'b00;

    case (state)
      FETCH: begin
        memread    = 1'b1;
        alusrcb    = 2'b01;
        irwrite    = mem_ready;
        pcen       = mem_ready;
        next_state = mem_ready ? DECODE : FETCH;
      end
      DECODE: begin
        // Branch target is computed here speculatively (PC + imm<<2).
        alusrcb = 2'b11;
        case (opcode)
          OP_LW, OP_SW: next_state = MEMADR;
          OP_RTYPE:     next_state = REXEC;
          OP_BEQ:       next_state = BEQEX;
          OP_ADDI:      next_state = ADDIEX;
          OP_J:         next_state = JEX;
          default: begin
            next_state   = FETCH;
            illegal_next = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = (opcode == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        memread    = 1'b1;
        iord       = 1'b1;
        next_state = mem_ready ? MEMWB : MEMRD;
      end
      MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        next_state = FETCH;
      end
      MEMWR: begin
        memwrite   = 1'b1;
        iord       = 1'b1;
        next_state = mem_ready ? FETCH : MEMWR;
      end
      REXEC: begin
        alusrca    = 1'b1;
        aluop      = 2'b10;
        next_state = RWB;
      end
      RWB: begin
        regwrite   = 1'b1;
        regdst     = 1'b1;
        next_state = FETCH;
      end
      BEQEX: begin
        alusrca    = 1'b1;
        aluop      = 2'b01;
        pcsrc      = 2'b01;
        pcen       = zero;
        next_state = FETCH;
      end
      ADDIEX: begin
        alusrca    = 1'b1;
        alusrcb    = 2'b10;
        next_state = ADDIWB;
      end
      ADDIWB: begin
        regwrite   = 1'b1;
        next_state = FETCH;
      end
      JEX: begin
        pcsrc      = 2'b10;
        pcen       = 1'b1;
        next_state = FETCH;
      end
      default: next_state = FETCH;
    endcase

    // While reset is held the state is already FETCH, but FETCH would still
    // request memory; suppress every enable so nothing moves during reset.
    if (!reset_n) begin
      pcen     = 1'b0;
      irwrite  = 1'b0;
      memread  = 1'b0;
      memwrite = 1'b0;
      regwrite = 1'b0;
    end
  end

  assign illegal_op = illegal_q;
  assign busy       = (state != FETCH);

endmodule

// File: tb/tb_mips_multicycle_control.sv
// tb_mips_multicycle_control
// Self-checking bench for mips_multicycle_control. An instruction-level model
// (instruction class + step number within the instruction) predicts every
// control output; a compare process checks the DUT on every falling edge.
// Directed sequences pin the model with hand-computed literal values, then
// a randomized run exercises random opcodes, zero and memory wait states.

module tb_mips_multicycle_control;

  logic       clk;
  logic       reset_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pcen, iord, memread, memwrite, irwrite, regdst, memtoreg;
  logic       regwrite, alusrca, illegal_op, busy;
  logic [1:0] alusrcb, aluop, pcsrc;

  typedef struct packed {
    logic       pcen;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
    logic       illegal_op;
    logic       busy;
  } ctl_t;

  typedef enum int {C_LW, C_SW, C_R, C_BEQ, C_ADDI, C_J, C_ILL} cls_e;

  int   checks = 0;
  int   fails  = 0;
  logic run    = 1'b0;

  // Model state: step 0 is the fetch, step 1 the decode, then the
  // instruction-specific steps.
  int   m_step = 0;
  cls_e m_cls  = C_ILL;
  logic m_ill  = 1'b0;

  ctl_t act;
  ctl_t want;

  logic [5:0] ops [6] = '{6'b100011, 6'b101011, 6'b000000,
                          6'b000100, 6'b001000, 6'b000010};

  mips_multicycle_control dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .zero(zero),
    .mem_ready(mem_ready), .pcen(pcen), .iord(iord), .memread(memread),
    .memwrite(memwrite), .irwrite(irwrite), .regdst(regdst),
    .memtoreg(memtoreg), .regwrite(regwrite), .alusrca(alusrca),
    .alusrcb(alusrcb), .aluop(aluop), .pcsrc(pcsrc),
    .illegal_op(illegal_op), .busy(busy)
  );

  assign act = {pcen, iord, memread, memwrite, irwrite, regdst, memtoreg,
                regwrite, alusrca, alusrcb, aluop, pcsrc, illegal_op, busy};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic cls_e cls_of(logic [5:0] op);
    case (op)
      6'b100011: return C_LW;
      6'b101011: return C_SW;
      6'b000000: return C_R;
      6'b000100: return C_BEQ;
      6'b001000: return C_ADDI;
      6'b000010: return C_J;
      default:   return C_ILL;
    endcase
  endfunction

  function automatic int steps_of(cls_e c);
    case (c)
      C_LW:           return 5;
      C_SW, C_R:      return 4;
      C_ADDI:         return 4;
      C_BEQ, C_J:     return 3;
      default:        return 2;
    endcase
  endfunction

  // Expected controls for a given step of a given instruction class.
  function automatic ctl_t model_out(int st, cls_e c, logic ill, logic z,
                                     logic mr, logic rn);
    ctl_t o;
    o      = '0;
    o.busy = (st != 0);
    case (st)
      0: begin
        o.memread    = 1'b1;
        o.alusrcb    = 2'b01;
        o.irwrite    = mr;
        o.pcen       = mr;
        o.illegal_op = ill;
      end
      1: o.alusrcb = 2'b11;
      2: begin
        if (c == C_LW || c == C_SW || c == C_ADDI) begin
          o.alusrca = 1'b1;
          o.alusrcb = 2'b10;
        end else if (c == C_R) begin
          o.alusrca = 1'b1;
          o.aluop   = 2'b10;
        end else if (c == C_BEQ) begin
          o.alusrca = 1'b1;
          o.aluop   = 2'b01;
          o.pcsrc   = 2'b01;
          o.pcen    = z;
        end else if (c == C_J) begin
          o.pcsrc = 2'b10;
          o.pcen  = 1'b1;
        end
      end
      3: begin
        if (c == C_LW) begin
          o.memread = 1'b1;
          o.iord    = 1'b1;
        end else if (c == C_SW) begin
          o.memwrite = 1'b1;
          o.iord     = 1'b1;
        end else if (c == C_R) begin
          o.regwrite = 1'b1;
          o.regdst   = 1'b1;
        end else if (c == C_ADDI) begin
          o.regwrite = 1'b1;
        end
      end
      4: begin
        o.regwrite = 1'b1;
        o.memtoreg = 1'b1;
      end
      default: ;
    endcase
    if (!rn) begin
      o.pcen       = 1'b0;
      o.irwrite    = 1'b0;
      o.memread    = 1'b0;
      o.memwrite   = 1'b0;
      o.regwrite   = 1'b0;
      o.illegal_op = 1'b0;
    end
    return o;
  endfunction

  // Reference model advance: one step per clock unless waiting on memory.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_step = 0;
      m_ill  = 1'b0;
    end else begin
      logic waiting;
      logic ill_next;
      waiting  = !mem_ready &&
                 (m_step == 0 || (m_step == 3 && (m_cls == C_LW || m_cls == C_SW)));
      ill_next = (m_step == 1) && (cls_of(opcode) == C_ILL);
      if (waiting) begin
        m_step = m_step;
      end else if (m_step == 1) begin
        m_cls  = cls_of(opcode);
        m_step = (m_cls == C_ILL) ? 0 : 2;
      end else if (m_step != 0 && m_step + 1 == steps_of(m_cls)) begin
        m_step = 0;
      end else begin
        m_step = m_step + 1;
      end
      m_ill = ill_next;
    end
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (run) begin
      want = model_out(m_step, m_cls, m_ill, zero, mem_ready, reset_n);
      checks++;
      if (act !== want) begin
        fails++;
        $display("[TB] FAIL cycle-compare t=%0t step=%0d got=%h want=%h",
                 $time, m_step, act, want);
      end
    end
  end

  task automatic checkOutput(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s t=%0t got=%0d want=%0d", name, $time, got, exp);
    end
  endtask

  // One clock: inputs change just after the rising edge, outputs are then
  // observable at the falling edge when this task returns.
  task automatic applyStimulus(input logic [5:0] op, input logic z, input logic mr);
    @(posedge clk);
    #1;
    opcode    = op;
    zero      = z;
    mem_ready = mr;
    @(negedge clk);
  endtask

  initial begin
    reset_n   = 1'b0;
    opcode    = 6'b000000;
    zero      = 1'b0;
    mem_ready = 1'b0;
    #3;
    checkOutput("reset_memread", int'(memread), 0);
    checkOutput("reset_alusrcb", int'(alusrcb), 1);
    checkOutput("reset_busy", int'(busy), 0);
    run = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    checkOutput("post_reset_memread", int'(memread), 1);

    // lw with memory always ready: five cycles, writeback in cycle 5.
    for (int c = 1; c <= 6; c++) begin
      applyStimulus(6'b100011, 1'b0, (c == 6) ? 1'b0 : 1'b1);
      if (c == 5) begin
        checkOutput("lw_c5_regwrite", int'(regwrite), 1);
        checkOutput("lw_c5_memtoreg", int'(memtoreg), 1);
      end
    end
    checkOutput("lw_c6_busy", int'(busy), 0);

    // sw with three wait cycles in the write state.
    for (int c = 1; c <= 8; c++) begin
      applyStimulus(6'b101011, 1'b0, (c == 4 || c == 5 || c == 6 || c == 8) ? 1'b0 : 1'b1);
      if (c >= 4 && c <= 7) begin
        checkOutput("sw_memwrite", int'(memwrite), 1);
        checkOutput("sw_iord", int'(iord), 1);
      end
      checkOutput("sw_regwrite", int'(regwrite), 0);
    end
    checkOutput("sw_done_busy", int'(busy), 0);

    // beq taken and not taken.
    for (int t = 0; t < 2; t++) begin
      for (int c = 1; c <= 4; c++) begin
        applyStimulus(6'b000100, (t == 0) ? 1'b1 : 1'b0, (c == 4) ? 1'b0 : 1'b1);
        if (c == 3) begin
          checkOutput("beq_pcen", int'(pcen), (t == 0) ? 1 : 0);
          checkOutput("beq_pcsrc", int'(pcsrc), 1);
          checkOutput("beq_aluop", int'(aluop), 1);
        end
      end
    end

    // R-type followed directly by addi: eight cycles total.
    for (int c = 1; c <= 9; c++) begin
      applyStimulus((c <= 4) ? 6'b000000 : 6'b001000, 1'b0, (c == 9) ? 1'b0 : 1'b1);
      if (c == 3) checkOutput("r_aluop", int'(aluop), 2);
      if (c == 4) checkOutput("r_regdst", int'(regdst), 1);
      if (c == 7) begin
        checkOutput("addi_aluop", int'(aluop), 0);
        checkOutput("addi_alusrcb", int'(alusrcb), 2);
      end
      if (c == 8) begin
        checkOutput("addi_regdst", int'(regdst), 0);
        checkOutput("addi_regwrite", int'(regwrite), 1);
      end
    end
    checkOutput("r_addi_done_busy", int'(busy), 0);

    // Unsupported opcode: single illegal_op pulse, no writes.
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(6'b111111, 1'b0, (c >= 3) ? 1'b0 : 1'b1);
      checkOutput("ill_pulse", int'(illegal_op), (c == 3) ? 1 : 0);
      checkOutput("ill_writes", int'(regwrite | memwrite), 0);
    end
    checkOutput("ill_back_fetch", int'(busy), 0);

    // Asynchronous reset while stalled in the lw memory read.
    for (int c = 1; c <= 4; c++) begin
      applyStimulus(6'b100011, 1'b0, (c == 4) ? 1'b0 : 1'b1);
    end
    checkOutput("rst_pre_memread", int'(memread), 1);
    checkOutput("rst_pre_iord", int'(iord), 1);
    #2 reset_n = 1'b0;
    #1;
    checkOutput("rst_now_memread", int'(memread), 0);
    checkOutput("rst_now_iord", int'(iord), 0);
    checkOutput("rst_now_busy", int'(busy), 0);
    checkOutput("rst_now_we", int'(regwrite | memwrite | pcen | irwrite), 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_rel_memread", int'(memread), 1);
    checkOutput("rst_rel_busy", int'(busy), 0);

    // Randomized run; opcode only changes while the model is fetching,
    // matching an instruction register that holds for the whole instruction.
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      #1;
      if (m_step == 0) begin
        opcode = ($urandom_range(0, 7) == 7) ? 6'($urandom) : ops[$urandom_range(0, 5)];
      end
      zero      = 1'($urandom_range(0, 1));
      mem_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 reset_n = 1'b0;
        #4 reset_n = 1'b1;
      end
    end

    @(negedge clk);
    run = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
